wb_write_arbiter: RTL and testbench

- Write-back stage directly upstream of the 32x64 two-write-port register file.
- Accepts results from two producer channels (A and B) over valid/ready handshakes and buffers each channel in its own FIFO.
- Drives the register file's two write ports from registered outputs; port B is the later, winning write on a same-address write.
- Same-address collisions between channels are serialised, so each write lands in acceptance order per channel with deterministic cross-channel order.
- Exports a pending-write mask so read-side logic can detect read-after-write hazards.

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_fifo.sv | 43 ++++
 rtl/wb_write_arbiter.sv | 85 ++++++++
 tb/tb_wb_write_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and entry type for the write-back arbiter
package wb_pkg;
  localparam int AW = 5;
  localparam int DW = 64;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular entry buffer with per-slot valid/address view for hazard decode
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       din,
  output wb_entry_t       head,
  output logic            empty,
  output logic            full,
  output logic [DEPTH-1:0] ent_vld,
  output logic [AW-1:0]   ent_addr [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  wb_entry_t     mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + {{(PW-1){1'b0}}, push};
      rd_q  <= rd_q + {{(PW-1){1'b0}}, pop};
      cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign head  = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_vld[i]  = {1'b0, PW'(i) - rd_q} < cnt_q;
    assign ent_addr[i] = mem_q[i].addr;
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: buffers two result channels and drives both register-file write ports
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [AW-1:0]      a_addr,
  input  logic [DW-1:0]      a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [AW-1:0]      b_addr,
  input  logic [DW-1:0]      b_data,
  output logic               wa_we,
  output logic [AW-1:0]      wa_addr,
  output logic [DW-1:0]      wa_data,
  output logic               wb_we,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
  output logic [2**AW-1:0]   pend_mask,
  output logic               idle
);
  wb_entry_t        a_head, b_head, wa_q, wb_q;
  logic             a_empty, a_full, b_empty, b_full;
  logic [DEPTH-1:0] a_vld, b_vld;
  logic [AW-1:0]    a_ents [DEPTH];
  logic [AW-1:0]    b_ents [DEPTH];
  logic             av, bv, same, pop_a, pop_b;
  logic             hold_b_q, hold_b_d, wa_we_q, wb_we_q;
  assign a_ready = !rst && !a_full;
  assign b_ready = !rst && !b_full;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push(a_valid && a_ready), .pop(pop_a),
    .din('{addr: a_addr, data: a_data}), .head(a_head), .empty(a_empty),
    .full(a_full), .ent_vld(a_vld), .ent_addr(a_ents)
  );
  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push(b_valid && b_ready), .pop(pop_b),
    .din('{addr: b_addr, data: b_data}), .head(b_head), .empty(b_empty),
    .full(b_full), .ent_vld(b_vld), .ent_addr(b_ents)
  );
  // A collision lets A go first and parks B for exactly one cycle via hold_b.
  always_comb begin
    av       = !a_empty;
    bv       = !b_empty;
    same     = a_head.addr == b_head.addr;
    pop_a    = hold_b_q ? av && !same : av;
    pop_b    = bv && (hold_b_q || !(av && same));
    hold_b_d = !hold_b_q && av && bv && same;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_b_q <= 1'b0;
      wa_we_q  <= 1'b0;
      wb_we_q  <= 1'b0;
      wa_q     <= '0;
      wb_q     <= '0;
    end else begin
      hold_b_q <= hold_b_d;
      wa_we_q  <= pop_a;
      wb_we_q  <= pop_b;
      if (pop_a) wa_q <= a_head;
      if (pop_b) wb_q <= b_head;
    end
  end
  assign wa_we   = wa_we_q;
  assign wa_addr = wa_q.addr;
  assign wa_data = wa_q.data;
  assign wb_we   = wb_we_q;
  assign wb_addr = wb_q.addr;
  assign wb_data = wb_q.data;
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) pend_mask[a_ents[i]] = 1'b1;
      if (b_vld[i]) pend_mask[b_ents[i]] = 1'b1;
    end
    if (wa_we_q) pend_mask[wa_q.addr] = 1'b1;
    if (wb_we_q) pend_mask[wb_q.addr] = 1'b1;
  end
  assign idle = a_empty && b_empty && !wa_we_q && !wb_we_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vector table plus hand sequences for streaming, collisions, full and reset
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [63:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, wa_we, wb_we, idle;
  logic [4:0]  wa_addr, wb_addr;
  logic [63:0] wa_data, wb_data;
  logic [31:0] pend_mask;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [63:0] bd;
    logic [174:0] exp;
  } vec_t;
  vec_t vt[12];
  logic [63:0] obs[$];
  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_mask(pend_mask), .idle(idle)
  );
  always #5 clk = ~clk;
  function automatic logic [174:0] outs();
    return {a_ready, b_ready, wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data, pend_mask, idle};
  endfunction
  function automatic vec_t mk(input int av, aa, ad, bv, ba, bd, ar, br,
                              wae, waa, wad, wbe, wba, wbd, pm, idl);
    vec_t v;
    v.av = av[0];
    v.aa = aa[4:0];
    v.ad = {32'b0, ad};
    v.bv = bv[0];
    v.ba = ba[4:0];
    v.bd = {32'b0, bd};
    v.exp = {ar[0], br[0], wae[0], waa[4:0], 32'b0, wad, wbe[0], wba[4:0], 32'b0, wbd, pm, idl[0]};
    return v;
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vt[0]  = mk(1, 3, 'hA5, 0, 0, 0,     1, 1, 0, 0, 0,    0, 0, 0,    'h8,  0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 1, 3, 'hA5, 0, 0, 0,    'h8,  0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 0, 3, 'hA5, 0, 0, 0,    0,    1);
    vt[3]  = mk(1, 7, 1, 1, 7, 2,        1, 1, 0, 3, 'hA5, 0, 0, 0,    'h80, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 1, 7, 1,    0, 0, 0,    'h80, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 0, 7, 1,    1, 7, 2,    'h80, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 0, 7, 1,    0, 7, 2,    0,    1);
    vt[7]  = mk(1, 1, 'h11, 1, 2, 'h22,  1, 1, 0, 7, 1,    0, 7, 2,    'h6,  0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 1, 1, 'h11, 1, 2, 'h22, 'h6,  0);
    vt[9]  = mk(0, 0, 0, 1, 0, 'h33,     1, 1, 0, 1, 'h11, 0, 2, 'h22, 'h1,  0);
    vt[10] = mk(0, 0, 0, 0, 0, 0,        1, 1, 0, 1, 'h11, 1, 0, 'h33, 'h1,  0);
    vt[11] = mk(0, 0, 0, 0, 0, 0,        1, 1, 0, 1, 'h11, 0, 0, 'h33, 0,    1);
    tick();
    tick();
    chk("reset_state", outs(), 175'd1);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {a_ready, b_ready}, 2'b11);
    for (int i = 0; i < 12; i++) begin
      a_valid = vt[i].av; a_addr = vt[i].aa; a_data = vt[i].ad;
      b_valid = vt[i].bv; b_addr = vt[i].ba; b_data = vt[i].bd;
      tick();
      chk($sformatf("vec%0d", i), outs(), vt[i].exp);
    end
    for (int c = 0; c < 10; c++) begin
      a_valid = c < 8; a_addr = 5'(c);     a_data = 64'(100 + c);
      b_valid = c < 8; b_addr = 5'(8 + c); b_data = 64'(200 + c);
      tick();
      if (c < 8) chk($sformatf("stream_ready%0d", c), {a_ready, b_ready}, 2'b11);
      if (c >= 1 && c <= 8) begin
        chk($sformatf("stream_a%0d", c), {wa_we, wa_addr, wa_data}, {1'b1, 5'(c - 1), 64'(100 + c - 1)});
        chk($sformatf("stream_b%0d", c), {wb_we, wb_addr, wb_data}, {1'b1, 5'(8 + c - 1), 64'(200 + c - 1)});
      end
    end
    chk("stream_idle", idle, 1'b1);
    begin
      int na = 0, nb = 0;
      logic acc_a, acc_b, saw_full = 1'b0;
      for (int c = 0; c < 60; c++) begin
        a_valid = na < 8; a_addr = 5'd5; a_data = 64'(300 + na);
        b_valid = nb < 8; b_addr = 5'd5; b_data = 64'(400 + nb);
        #1;
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        if (a_valid && !a_ready) saw_full = 1'b1;
        tick();
        if (acc_a) na++;
        if (acc_b) nb++;
        if (wa_we) obs.push_back({1'b0, wa_data[62:0]});
        if (wb_we) obs.push_back({1'b1, wb_data[62:0]});
        chk($sformatf("coll_excl%0d", c), wa_we && wb_we, 1'b0);
        if (na == 8 && nb == 8 && idle) break;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      chk("full_stall_seen", saw_full, 1'b1);
      chk("coll_count", 32'(obs.size()), 32'd16);
      for (int i = 0; i < obs.size() && i < 16; i++)
        chk($sformatf("coll_order%0d", i), obs[i],
            (i % 2 == 0) ? {1'b0, 63'(300 + i / 2)} : {1'b1, 63'(400 + i / 2)});
    end
    for (int c = 0; c < 3; c++) begin
      a_valid = 1'b1; a_addr = 5'd9; a_data = 64'(500 + c);
      b_valid = 1'b1; b_addr = 5'd9; b_data = 64'(600 + c);
      tick();
    end
    chk("pre_reset_busy", idle, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    #1;
    chk("ready_low_in_rst", {a_ready, b_ready}, 2'b00);
    tick();
    chk("mid_reset_state", {wa_we, wb_we, pend_mask, idle}, {2'b00, 32'd0, 1'b1});
    rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", {a_ready, b_ready}, 2'b11);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("discarded%0d", c), {wa_we, wb_we, pend_mask, idle}, {2'b00, 32'd0, 1'b1});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
